// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA timing from per-segment parameters, with pixel coordinates and frame-buffer address for renderers.
// Also drives latency-aligned sync/blank/RGB to the DAC; defining VGA_TEST_PATTERN_EN swaps the colour source for an 8-bar pattern.
module vga_scan_engine #(
    parameter int   COLOR_DEPTH = 9,
    parameter int   H_ACTIVE    = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_ACTIVE    = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic HS_POL      = 1'b0,
    parameter logic VS_POL      = 1'b0,
    parameter int   PIPE_DELAY  = 2,
    parameter int   Mn          = 19,
    localparam int  H_TOTAL     = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int  V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int  XW          = $clog2(H_TOTAL),
    localparam int  YW          = $clog2(V_TOTAL)
) (
    input  logic                   vga_clock,
    input  logic                   reset,
    input  logic [COLOR_DEPTH-1:0] pixel_color,
    output logic [XW-1:0]          x,
    output logic [YW-1:0]          y,
    output logic [Mn-1:0]          memory_address,
    output logic                   frame_start,
    output logic                   line_start,
    output logic [7:0]             VGA_R,
    output logic [7:0]             VGA_G,
    output logic [7:0]             VGA_B,
    output logic                   VGA_HS,
    output logic                   VGA_VS,
    output logic                   VGA_BLANK_N,
    output logic                   VGA_SYNC_N,
    output logic                   VGA_CLK
);
    localparam int CB  = COLOR_DEPTH / 3;
    localparam int REP = (8 + CB - 1) / CB;
`ifdef VGA_TEST_PATTERN_EN
    localparam int SW = 6;
`else
    localparam int SW = 3;
`endif

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic          x_wrap, active, hs_raw, vs_raw;
    logic [SW-1:0] s0, tap;
    logic [7:0]    src_r, src_g, src_b;
    logic [7:0]    r_q, g_q, b_q, r_d, g_d, b_d;
    logic          hs_q, vs_q, blank_q, hs_d, vs_d, blank_d;

    assign x_wrap = x_q == XW'(H_TOTAL - 1);

    always_comb begin
        x_d = x_wrap ? '0 : x_q + XW'(1);
        y_d = !x_wrap ? y_q : (y_q == YW'(V_TOTAL - 1) ? '0 : y_q + YW'(1));
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign active = x_q < XW'(H_ACTIVE) && y_q < YW'(V_ACTIVE);
    assign hs_raw = x_q >= XW'(H_ACTIVE + H_FP) && x_q <= XW'(H_ACTIVE + H_FP + H_SYNC - 1);
    assign vs_raw = y_q >= YW'(V_ACTIVE + V_FP) && y_q <= YW'(V_ACTIVE + V_FP + V_SYNC - 1);

    assign x              = x_q;
    assign y              = y_q;
    assign memory_address = active ? Mn'(32'(y_q) * H_ACTIVE + 32'(x_q)) : '0;
    assign frame_start    = x_q == '0 && y_q == '0;
    assign line_start     = x_q == '0 && y_q < YW'(V_ACTIVE);

`ifdef VGA_TEST_PATTERN_EN
    logic [2:0] bar;
    logic       unused_pix;
    assign bar        = 3'(32'(x_q) * 8 / H_ACTIVE);
    assign unused_pix = ^pixel_color;
    assign s0         = {bar, vs_raw, hs_raw, active};
`else
    assign s0 = {vs_raw, hs_raw, active};
`endif

    // Reset clears every stage so a mid-frame reset cannot leak stale pixels.
    generate
        if (PIPE_DELAY == 0) begin : g_direct
            assign tap = s0;
        end else begin : g_delay
            logic [SW-1:0] sr_q [PIPE_DELAY];
            always_ff @(posedge vga_clock) begin
                if (reset) begin
                    sr_q <= '{default: '0};
                end else begin
                    sr_q[0] <= s0;
                    for (int i = 1; i < PIPE_DELAY; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign tap = sr_q[PIPE_DELAY-1];
        end
    endgenerate

    // MSB-first replication of a CB-bit component, truncated to 8 bits.
    function automatic logic [7:0] expand(input logic [CB-1:0] c);
        logic [CB*REP-1:0] rep;
        rep = {REP{c}};
        return rep[CB*REP-1 -: 8];
    endfunction

`ifdef VGA_TEST_PATTERN_EN
    assign src_r = {8{tap[5]}};
    assign src_g = {8{tap[4]}};
    assign src_b = {8{tap[3]}};
`else
    assign src_r = expand(pixel_color[3*CB-1:2*CB]);
    assign src_g = expand(pixel_color[2*CB-1:CB]);
    assign src_b = expand(pixel_color[CB-1:0]);
`endif

    always_comb begin
        blank_d = tap[0];
        hs_d    = tap[1] ? HS_POL : ~HS_POL;
        vs_d    = tap[2] ? VS_POL : ~VS_POL;
        r_d     = tap[0] ? src_r : '0;
        g_d     = tap[0] ? src_g : '0;
        b_d     = tap[0] ? src_b : '0;
    end

    always_ff @(posedge vga_clock) begin
        if (reset) begin
            hs_q    <= ~HS_POL;
            vs_q    <= ~VS_POL;
            blank_q <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            blank_q <= blank_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign VGA_R       = r_q;
    assign VGA_G       = g_q;
    assign VGA_B       = b_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = blank_q;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_CLK     = vga_clock;
endmodule

// File: tb/tb_vga_scan_engine.sv
// tb_vga_scan_engine: directed checks on a default-size engine, a tiny positive-polarity engine and a zero-delay 320x240 engine.
module tb_vga_scan_engine;
    logic clk = 1'b0;
    logic rst_a = 1'b1;
    logic rst_bc = 1'b1;
    logic [8:0] pix_a = 9'b111_000_101;
    logic [5:0] pix_b = 6'b10_01_11;
    logic [8:0] pix_c = 9'b000_000_111;
    int pass = 0;
    int total = 0;

    always #5 clk = ~clk;

    logic [9:0]  a_x, a_y;
    logic [18:0] a_addr;
    logic        a_fs, a_ls, a_hs, a_vs, a_blank, a_sync_n, a_vclk;
    logic [7:0]  a_r, a_g, a_b;
    logic [4:0]  b_x;
    logic [3:0]  b_y;
    logic [18:0] b_addr;
    logic        b_fs, b_ls, b_hs, b_vs, b_blank, b_sync_n, b_vclk;
    logic [7:0]  b_r, b_g, b_b;
    logic [8:0]  c_x, c_y;
    logic [18:0] c_addr;
    logic        c_fs, c_ls, c_hs, c_vs, c_blank, c_sync_n, c_vclk;
    logic [7:0]  c_r, c_g, c_b;

    vga_scan_engine dut_a (
        .vga_clock(clk), .reset(rst_a), .pixel_color(pix_a), .x(a_x), .y(a_y),
        .memory_address(a_addr), .frame_start(a_fs), .line_start(a_ls),
        .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .VGA_HS(a_hs), .VGA_VS(a_vs),
        .VGA_BLANK_N(a_blank), .VGA_SYNC_N(a_sync_n), .VGA_CLK(a_vclk)
    );

    vga_scan_engine #(
        .COLOR_DEPTH(6), .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .PIPE_DELAY(1)
    ) dut_b (
        .vga_clock(clk), .reset(rst_bc), .pixel_color(pix_b), .x(b_x), .y(b_y),
        .memory_address(b_addr), .frame_start(b_fs), .line_start(b_ls),
        .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .VGA_HS(b_hs), .VGA_VS(b_vs),
        .VGA_BLANK_N(b_blank), .VGA_SYNC_N(b_sync_n), .VGA_CLK(b_vclk)
    );

    vga_scan_engine #(
        .H_ACTIVE(320), .V_ACTIVE(240), .PIPE_DELAY(0)
    ) dut_c (
        .vga_clock(clk), .reset(rst_bc), .pixel_color(pix_c), .x(c_x), .y(c_y),
        .memory_address(c_addr), .frame_start(c_fs), .line_start(c_ls),
        .VGA_R(c_r), .VGA_G(c_g), .VGA_B(c_b), .VGA_HS(c_hs), .VGA_VS(c_vs),
        .VGA_BLANK_N(c_blank), .VGA_SYNC_N(c_sync_n), .VGA_CLK(c_vclk)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] exp_c(input int px);
`ifdef VGA_TEST_PATTERN_EN
        logic [2:0] idx;
        idx = 3'(px * 8 / 320);
        return {{8{idx[2]}}, {8{idx[1]}}, {8{idx[0]}}};
`else
        return 24'h0000FF;
`endif
    endfunction

    task automatic test_reset;
        int bad = 0;
        rst_a = 1'b1;
        rst_bc = 1'b1;
        repeat (5) tick;
        total++; if (a_hs !== 1'b1) $display("FAIL rst_hs: got %b want 1", a_hs); else pass++;
        total++; if (a_vs !== 1'b1) $display("FAIL rst_vs: got %b want 1", a_vs); else pass++;
        total++; if (a_blank !== 1'b0) $display("FAIL rst_blank: got %b want 0", a_blank); else pass++;
        total++; if ({a_r, a_g, a_b} !== 24'h0) $display("FAIL rst_rgb: got %h want 0", {a_r, a_g, a_b}); else pass++;
        total++; if ({b_hs, b_vs} !== 2'b00) $display("FAIL rst_pol: got %b want 00", {b_hs, b_vs}); else pass++;
        rst_a = 1'b0;
        rst_bc = 1'b0;
        total++; if ({a_x, a_y} !== 20'h0) $display("FAIL first_xy: got %0d,%0d want 0,0", a_x, a_y); else pass++;
        total++; if ({a_fs, a_ls, b_fs, c_fs} !== 4'hF) $display("FAIL first_pulses: got %b want 1111", {a_fs, a_ls, b_fs, c_fs}); else pass++;
        total++; if (a_sync_n !== 1'b1) $display("FAIL sync_n: got %b want 1", a_sync_n); else pass++;
        for (int i = 0; i < 3; i++) begin
            if (a_blank !== 1'b0 || {a_r, a_g, a_b} !== 24'h0) bad++;
            tick;
        end
        total++; if (bad != 0) $display("FAIL lat_dark: got %0d early pixels want 0", bad); else pass++;
        total++; if (a_blank !== 1'b1) $display("FAIL lat_rise: got %b want 1", a_blank); else pass++;
        total++; if ({a_r, a_g, a_b} !== 24'hFF00B6) $display("FAIL first_rgb: got %h want FF00B6", {a_r, a_g, a_b}); else pass++;
    endtask

    task automatic test_line;
        int n, hs_cnt = 0, hs_first = -1, bl_cnt = 0, col_bad = 0, dark_bad = 0, x_bad = 0;
        logic [18:0] addr700 = '1;
        for (n = 0; n < 1000 && a_ls !== 1'b1; n++) tick;
        total++; if (a_ls !== 1'b1) $display("FAIL line_wait: got %b want 1", a_ls); else pass++;
        for (int i = 0; i < 800; i++) begin
            if (int'(a_x) != i) x_bad++;
            if (a_hs === 1'b0) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (a_blank === 1'b1) begin
                bl_cnt++;
                if ({a_r, a_g, a_b} !== 24'hFF00B6) col_bad++;
            end else if ({a_r, a_g, a_b} !== 24'h0) dark_bad++;
            if (i == 700) addr700 = a_addr;
            tick;
        end
        total++; if (x_bad != 0) $display("FAIL x_count: got %0d bad want 0", x_bad); else pass++;
        total++; if (hs_first != 659) $display("FAIL hs_start: got %0d want 659", hs_first); else pass++;
        total++; if (hs_cnt != 96) $display("FAIL hs_width: got %0d want 96", hs_cnt); else pass++;
        total++; if (bl_cnt != 640) $display("FAIL blank_width: got %0d want 640", bl_cnt); else pass++;
        total++; if (col_bad != 0) $display("FAIL rgb_active: got %0d bad want 0", col_bad); else pass++;
        total++; if (dark_bad != 0) $display("FAIL rgb_blank: got %0d bad want 0", dark_bad); else pass++;
        total++; if (addr700 !== 19'd0) $display("FAIL addr_blank: got %0d want 0", addr700); else pass++;
    endtask

    task automatic test_address;
        int n;
        for (n = 0; n < 2000 && !(a_x === 10'd5 && a_y === 10'd2); n++) tick;
        total++; if (a_addr !== 19'd1285) $display("FAIL addr_5_2: got %0d want 1285 at %0d,%0d", a_addr, a_x, a_y); else pass++;
        total++; if (a_ls !== 1'b0) $display("FAIL ls_mid: got %b want 0", a_ls); else pass++;
    endtask

    task automatic test_colour;
        int n;
        pix_a = 9'b010_110_001;
        for (n = 0; n < 1000 && a_ls !== 1'b1; n++) tick;
        repeat (20) tick;
        total++; if ({a_blank, a_r, a_g, a_b} !== {1'b1, 24'h49DB24}) $display("FAIL rgb_alt: got %b %h want 1 49DB24", a_blank, {a_r, a_g, a_b}); else pass++;
        pix_a = 9'b111_000_101;
    endtask

    task automatic test_mid_reset;
        int n, bad = 0;
        for (n = 0; n < 1000 && a_x !== 10'd300; n++) tick;
        total++; if (a_y === 10'd0) $display("FAIL mid_pos: got y %0d want nonzero", a_y); else pass++;
        rst_a = 1'b1;
        tick;
        total++; if ({a_x, a_y, a_fs} !== {20'h0, 1'b1}) $display("FAIL mid_xy: got %0d,%0d fs %b want 0,0 fs 1", a_x, a_y, a_fs); else pass++;
        rst_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (a_blank !== 1'b0 || {a_r, a_g, a_b} !== 24'h0) bad++;
            tick;
        end
        total++; if (bad != 0) $display("FAIL mid_flush: got %0d stale pixels want 0", bad); else pass++;
        total++; if ({a_blank, a_r, a_g, a_b} !== {1'b1, 24'hFF00B6}) $display("FAIL mid_rise: got %b %h want 1 FF00B6", a_blank, {a_r, a_g, a_b}); else pass++;
    endtask

    task automatic test_small_frame;
        int n, extra_fs = 0, vs_cnt = 0, vs_first = -1, hs_cnt = 0, hs_first = -1;
        logic [23:0] col5 = '0;
        for (n = 0; n < 400 && b_fs !== 1'b1; n++) tick;
        total++; if (b_fs !== 1'b1) $display("FAIL b_wait: got %b want 1", b_fs); else pass++;
        for (int i = 0; i < 288; i++) begin
            if (i > 0 && b_fs === 1'b1) extra_fs++;
            if (b_vs === 1'b1) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = i;
            end
            if (i < 24 && b_hs === 1'b1) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = i;
            end
            if (i == 5) col5 = {b_r, b_g, b_b};
            tick;
        end
        total++; if (b_fs !== 1'b1) $display("FAIL b_period: got %b want 1 at 288", b_fs); else pass++;
        total++; if (extra_fs != 0) $display("FAIL b_fs_extra: got %0d want 0", extra_fs); else pass++;
        total++; if (vs_first != 218) $display("FAIL b_vs_start: got %0d want 218", vs_first); else pass++;
        total++; if (vs_cnt != 48) $display("FAIL b_vs_width: got %0d want 48", vs_cnt); else pass++;
        total++; if (hs_first != 20) $display("FAIL b_hs_start: got %0d want 20", hs_first); else pass++;
        total++; if (hs_cnt != 4) $display("FAIL b_hs_width: got %0d want 4", hs_cnt); else pass++;
        total++; if (col5 !== 24'hAA55FF) $display("FAIL b_rgb: got %h want AA55FF", col5); else pass++;
    endtask

    task automatic test_pattern;
        int n;
        logic bl0 = 1'b1, bl1 = 1'b0, bl320 = 1'b0, bl321 = 1'b1;
        logic [23:0] c40 = '0, c41 = '0, c46 = '0, c320 = '0;
        for (n = 0; n < 1000 && c_ls !== 1'b1; n++) tick;
        total++; if (c_ls !== 1'b1) $display("FAIL c_wait: got %b want 1", c_ls); else pass++;
        for (int i = 0; i < 322; i++) begin
            if (i == 0) bl0 = c_blank;
            if (i == 1) bl1 = c_blank;
            if (i == 40) c40 = {c_r, c_g, c_b};
            if (i == 41) c41 = {c_r, c_g, c_b};
            if (i == 46) c46 = {c_r, c_g, c_b};
            if (i == 320) begin
                bl320 = c_blank;
                c320 = {c_r, c_g, c_b};
            end
            if (i == 321) bl321 = c_blank;
            tick;
        end
        total++; if ({bl0, bl1} !== 2'b01) $display("FAIL c_rise: got %b want 01", {bl0, bl1}); else pass++;
        total++; if (c40 !== exp_c(39)) $display("FAIL c_x39: got %h want %h", c40, exp_c(39)); else pass++;
        total++; if (c41 !== exp_c(40)) $display("FAIL c_x40: got %h want %h", c41, exp_c(40)); else pass++;
        total++; if (c46 !== 24'h0000FF) $display("FAIL c_x45: got %h want 0000FF", c46); else pass++;
        total++; if ({bl320, c320} !== {1'b1, exp_c(319)}) $display("FAIL c_x319: got %b %h want 1 %h", bl320, c320, exp_c(319)); else pass++;
        total++; if (bl321 !== 1'b0) $display("FAIL c_fall: got %b want 0", bl321); else pass++;
    endtask

    initial begin
        test_reset;
        test_line;
        test_address;
        test_colour;
        test_mid_reset;
        test_small_frame;
        test_pattern;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/vga_scan_engine.md
# vga_scan_engine

Parametrised VGA scan engine: the next generation of the game's display controller. It generates horizontal/vertical timing for any resolution from per-segment parameters and exposes pixel coordinates and a frame-buffer address to upstream renderers. It also delay-aligns sync and blank to a configurable pixel-source latency and expands packed colour to 24-bit DAC outputs. It sits between the maze/sprite renderers plus background ROM and the board's VGA DAC pins.

## Interface
Parameters:
- COLOR_DEPTH, 9, packed RGB width; multiple of 3, at most 24
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- HS_POL, 0, active level of VGA_HS (0 = active-low)
- VS_POL, 0, active level of VGA_VS
- PIPE_DELAY, 2, cycles from x/y/memory_address to the matching pixel_color; range 0–7
- Mn, 19, memory_address width

Ports:
- vga_clock  in  1  pixel clock
- reset  in  1  synchronous, active-high
- pixel_color  in  COLOR_DEPTH  packed {R,G,B} for the coordinate issued PIPE_DELAY cycles earlier
- x  out  XW = $clog2(H_TOTAL)  current horizontal count
- y  out  YW = $clog2(V_TOTAL)  current vertical count
- memory_address  out  Mn  y*H_ACTIVE + x while active, else 0
- frame_start  out  1  one-cycle pulse at x=0, y=0
- line_start  out  1  one-cycle pulse at x=0 when y < V_ACTIVE
- VGA_R, VGA_G, VGA_B  out  8 each  DAC colour
- VGA_HS, VGA_VS  out  1  syncs
- VGA_BLANK_N  out  1  high during visible pixels
- VGA_SYNC_N  out  1  constant 1
- VGA_CLK  out  1  vga_clock passthrough

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL is defined the same way.
- Stage 0 (counters):
  - x increments every cycle and wraps H_TOTAL-1 → 0.
  - y increments on x wrap and wraps V_TOTAL-1 → 0 when x and y wrap together.
- x, y, memory_address, frame_start and line_start are combinational from stage 0.
- memory_address is computed in full width, then truncated to Mn.
- Raw stage-0 signals:
  - active = x<H_ACTIVE && y<V_ACTIVE
  - hs_raw asserted for x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]
  - vs_raw asserted for y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]
- active, hs_raw and vs_raw pass through a PIPE_DELAY-deep shift register, then one output register.
- pixel_color is registered in that same output register.
- Outputs HS/VS/BLANK_N/RGB therefore lag stage 0 by L = PIPE_DELAY+1 cycles and are mutually aligned.
- Colour expansion:
  - B = COLOR_DEPTH/3.
  - Each component is replicated MSB-first to fill 8 bits, then truncated. Example: 3'b101 → 8'hB6.
  - RGB is forced to 0 when delayed active = 0.
- Sync level is HS_POL/VS_POL when asserted, the inverse otherwise.

## Timing
- Reset, sampled on vga_clock:
  - x=0, y=0, all delay stages cleared (inactive).
  - VGA_HS=~HS_POL, VGA_VS=~VS_POL, VGA_BLANK_N=0, RGB=0.
- frame_start and line_start are 1 on the first cycle after reset release, because the counters are at 0,0.
- Reset mid-line or mid-frame:
  - Counters return to 0,0 the next edge.
  - The pipeline is flushed, so no stale pixel appears within L cycles.
  - Outputs stay inactive until the delayed stage-0 state reaches them.
- Frame period is exactly H_TOTAL*V_TOTAL cycles; it is 420000 with defaults.
- Latency L applies equally to all DAC outputs. memory_address has zero latency relative to x/y.

## Configuration
- VGA_TEST_PATTERN_EN defined:
  - The output-register colour source is an internal 8-bar pattern.
  - Bar index = x*8/H_ACTIVE (computed at stage 0 and delayed with active).
  - Bar colour bits: R=idx[2], G=idx[1], B=idx[0]; each bit replicated to all 8 DAC bits.
  - pixel_color is ignored. memory_address and timing are unchanged.
- Undefined: pixel_color is the colour source as described in Operation.

## Test plan
- Reset held 5 cycles:
  - During reset: VGA_HS=VGA_VS=1 (defaults), VGA_BLANK_N=0, RGB=0.
  - First cycle after release: x=0, y=0, frame_start=1.
- Free run with defaults:
  - VGA_HS low for exactly 96 cycles per line, starting L=3 cycles after x=656.
  - VGA_VS low for 2 lines, starting at y=490.
  - frame_start period is 420000 cycles.
- Address check:
  - x=5, y=2 gives memory_address=1285.
  - x=700 (blanking) gives memory_address=0.
- Colour path, pixel_color=9'b111_000_101 held during the active region:
  - VGA_R=8'hFF, VGA_G=8'h00, VGA_B=8'hB6.
  - All three channels are 0 whenever VGA_BLANK_N=0.
- Reset asserted 1 cycle at x=300, y=100:
  - Next cycle x=0, y=0.
  - VGA_BLANK_N stays 0 until L cycles after release, then rises together with the first pixel.
- PIPE_DELAY=0, H_ACTIVE=320, V_ACTIVE=240, with VGA_TEST_PATTERN_EN:
  - VGA_BLANK_N rises 1 cycle after x=0.
  - Bars change every 40 pixels.
  - Pixel x=45 outputs R=00, G=00, B=FF.
